// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_ls load/store data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size.
  function automatic int unsigned size_bytes(size_t s);
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_ls: store lane mask/shift and load extract/extend.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned NB = DATA_WIDTH / 8,
  localparam int unsigned OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0]      offset,
  input  size_t                 size,
  input  logic                  uns,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [NB-1:0]         be,
  output logic [DATA_WIDTH-1:0] wdata_sh,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned
);

  int unsigned           nbytes;
  int unsigned           eff;
  logic [DATA_WIDTH-1:0] shifted;
  logic [7:0]            top_byte;
  logic                  sign;

  always_comb begin
    nbytes     = size_bytes(size);
    // An unsupported double on a narrow word is flagged upstream; clamp so indexing stays in range.
    eff        = (nbytes > NB) ? NB : nbytes;
    misaligned = (32'(offset) & (nbytes - 32'd1)) != 32'd0;
    shifted    = raw >> {offset, 3'b000};
    wdata_sh   = wdata << {offset, 3'b000};
    top_byte   = 8'h00;
    for (int b = 0; b < int'(NB); b++) begin
      be[b] = (b >= int'(offset)) && (b < int'(offset) + int'(nbytes));
      if (b == int'(eff) - 1) top_byte = shifted[8*b +: 8];
    end
    sign = ~uns & top_byte[7];
    for (int b = 0; b < int'(NB); b++) begin
      rdata[8*b +: 8] = (b < int'(eff)) ? shifted[8*b +: 8] : {8{sign}};
    end
  end

endmodule

// File: rtl/dmem_ls.sv
// Parametrised load/store data memory with valid/ready handshake and fixed read latency.
module dmem_ls
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned MEM_DEPTH    = 128,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned OFF = $clog2(NB);
  localparam int unsigned IW  = ADDR_WIDTH - OFF;
  localparam int unsigned MW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CW  = 3;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_RESP = RESP;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]            state_q, next_state;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_ready_q, ready_d;
  logic                  rsp_valid_q, valid_d;
  logic                  rsp_err_q, err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] pend_rdata_q;
  logic                  pend_err_q;

  logic [OFF-1:0]        offset;
  logic [IW-1:0]         idx;
  logic [MW-1:0]         mem_idx;
  logic                  in_range, unsupported, misaligned, req_err, accept;
  logic [DATA_WIDTH-1:0] raw, wdata_sh, ld_data, rsp_data;
  logic [NB-1:0]         be;

  // Request decode and error classification
  assign offset      = i_req_addr[OFF-1:0];
  assign idx         = i_req_addr[ADDR_WIDTH-1:OFF];
  assign in_range    = 32'(idx) < MEM_DEPTH;
  assign mem_idx     = MW'(idx);
  assign raw         = in_range ? mem[mem_idx] : '0;
  assign unsupported = (i_req_size == 2'(SZ_D)) && (DATA_WIDTH == 32);
  assign req_err     = misaligned | ~in_range | unsupported;
  assign accept      = i_req_valid & req_ready_q & ~i_arst;
  assign rsp_data    = (i_req_we | req_err) ? '0 : ld_data;

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .offset     (offset),
    .size       (size_t'(i_req_size)),
    .uns        (i_req_unsigned),
    .wdata      (i_req_wdata),
    .raw        (raw),
    .be         (be),
    .wdata_sh   (wdata_sh),
    .rdata      (ld_data),
    .misaligned (misaligned)
  );

  // Stores commit on the accept edge, so a later reset cannot undo them.
  always_ff @(posedge i_clk) begin
    if (accept && i_req_we && !req_err) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) mem[mem_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_comb begin
    next_state = state_q;
    cnt_d      = cnt_q;
    ready_d    = req_ready_q;
    valid_d    = rsp_valid_q;
    err_d      = rsp_err_q;
    rdata_d    = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          if (READ_LATENCY > 1) begin
            next_state = S_WAIT;
            cnt_d      = CW'(READ_LATENCY - 1);
          end else begin
            next_state = S_RESP;
            valid_d    = 1'b1;
            err_d      = req_err;
            rdata_d    = rsp_data;
          end
        end
      end
      S_WAIT: begin
        ready_d = 1'b0;
        if (cnt_q == CW'(1)) begin
          next_state = S_RESP;
          cnt_d      = '0;
          valid_d    = 1'b1;
          err_d      = pend_err_q;
          rdata_d    = pend_rdata_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        ready_d = 1'b0;
        if (i_rsp_ready) begin
          next_state = S_IDLE;
          ready_d    = 1'b1;
          valid_d    = 1'b0;
          err_d      = 1'b0;
          rdata_d    = '0;
        end
      end
      default: begin
        next_state = S_IDLE;
        cnt_d      = '0;
        ready_d    = 1'b1;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
    end else begin
      state_q     <= next_state;
      cnt_q       <= cnt_d;
      req_ready_q <= ready_d;
      rsp_valid_q <= valid_d;
      rsp_err_q   <= err_d;
      rsp_rdata_q <= rdata_d;
      if (accept) begin
        pend_rdata_q <= rsp_data;
        pend_err_q   <= req_err;
      end
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_ls.sv
// Self-checking bench for dmem_ls against a byte-array reference model.
module tb_dmem_ls;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned RL    = 3;

  logic          clk = 1'b0;
  logic          i_arst = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_we = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [1:0]    i_req_size = 2'd0;
  logic          i_req_unsigned = 1'b0;
  logic [DW-1:0] i_req_wdata = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b0;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mm [DEPTH*8];

  always #5 clk = ~clk;

  dmem_ls #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .MEM_DEPTH    (DEPTH),
    .READ_LATENCY (RL)
  ) dut (
    .i_clk          (clk),
    .i_arst         (i_arst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_addr     (i_req_addr),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_err      (o_rsp_err)
  );

  // Reference: memory as a flat byte array, accesses as byte loops.
  function automatic void model(input logic we, input int unsigned addr, input int unsigned size,
                                input logic uns, input logic [63:0] wd,
                                output logic err, output logic [63:0] rd);
    int unsigned nb;
    logic [63:0] v;
    nb  = 1 << size;
    err = ((addr % nb) != 0) || ((addr / 8) >= DEPTH);
    rd  = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < int'(nb); i++) mm[addr + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < int'(nb); i++) v[8*i +: 8] = mm[addr + i];
        if (!uns && nb < 8 && v[8*nb - 1])
          for (int i = int'(nb); i < 8; i++) v[8*i +: 8] = 8'hFF;
        rd = v;
      end
    end
  endfunction

  task automatic drive(input logic we, input int unsigned addr, input int unsigned size,
                       input logic uns, input logic [63:0] wd);
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_addr     = AW'(addr);
    i_req_size     = 2'(size);
    i_req_unsigned = uns;
    i_req_wdata    = wd;
  endtask

  // One full transaction; lat counts cycles from accept edge to response valid (20 = timeout).
  task automatic do_req(input logic we, input int unsigned addr, input int unsigned size,
                        input logic uns, input logic [63:0] wd,
                        output logic [63:0] rd, output logic err, output int lat);
    int budget;
    budget = 0;
    while (!o_req_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    drive(we, addr, size, uns, wd);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = o_rsp_rdata;
    err = o_rsp_err;
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", o_rsp_valid); end
    n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", o_req_ready); end
    n_vec++; if (o_rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b exp 0", o_rsp_err); end
    n_vec++; if (o_rsp_rdata !== 64'd0) begin n_err++; $display("FAIL reset_rdata: got %h exp 0", o_rsp_rdata); end
    i_arst = 1'b0;
  endtask

  task automatic test_fill();
    logic [63:0] rd, erd, wd;
    logic err, eerr;
    int lat;
    for (int w = 0; w < int'(DEPTH); w++) begin
      wd = {$urandom, $urandom};
      model(1'b1, 8 * w, 3, 1'b0, wd, eerr, erd);
      do_req(1'b1, 8 * w, 3, 1'b0, wd, rd, err, lat);
      n_vec++; if (err !== eerr || rd !== erd || lat != int'(RL)) begin
        n_err++; $display("FAIL fill_store[%0d]: got err=%b rd=%h lat=%0d exp err=%b rd=%h lat=%0d", w, err, rd, lat, eerr, erd, RL);
      end
    end
  endtask

  task automatic test_double();
    logic [63:0] rd, erd;
    logic err, eerr;
    int lat;
    model(1'b1, 32'h010, 3, 1'b0, 64'h1122334455667788, eerr, erd);
    do_req(1'b1, 32'h010, 3, 1'b0, 64'h1122334455667788, rd, err, lat);
    n_vec++; if (err !== 1'b0 || rd !== 64'd0) begin n_err++; $display("FAIL dbl_store_ack: got err=%b rd=%h exp err=0 rd=0", err, rd); end
    n_vec++; if (lat != int'(RL)) begin n_err++; $display("FAIL dbl_store_lat: got %0d exp %0d", lat, RL); end
    model(1'b0, 32'h010, 3, 1'b0, 64'd0, eerr, erd);
    do_req(1'b0, 32'h010, 3, 1'b0, 64'd0, rd, err, lat);
    n_vec++; if (rd !== 64'h1122334455667788) begin n_err++; $display("FAIL dbl_load_rdata: got %h exp 1122334455667788", rd); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL dbl_load_err: got %b exp 0", err); end
    n_vec++; if (lat != int'(RL)) begin n_err++; $display("FAIL dbl_load_lat: got %0d exp %0d", lat, RL); end
  endtask

  task automatic test_byte_lanes();
    logic [63:0] rd, erd;
    logic err, eerr;
    int lat;
    model(1'b1, 32'h013, 0, 1'b0, 64'hAB, eerr, erd);
    do_req(1'b1, 32'h013, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB, rd, err, lat);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL byte_store_err: got %b exp 0", err); end
    model(1'b0, 32'h010, 3, 1'b0, 64'd0, eerr, erd);
    do_req(1'b0, 32'h010, 3, 1'b0, 64'd0, rd, err, lat);
    n_vec++; if (rd !== 64'h11223344AB667788) begin n_err++; $display("FAIL byte_lanes: got %h exp 11223344ab667788", rd); end
  endtask

  task automatic test_extension();
    logic [63:0] rd, erd;
    logic err, eerr;
    int lat;
    model(1'b1, 32'h020, 1, 1'b0, 64'h8001, eerr, erd);
    do_req(1'b1, 32'h020, 1, 1'b0, 64'h8001, rd, err, lat);
    do_req(1'b0, 32'h020, 1, 1'b0, 64'd0, rd, err, lat);
    n_vec++; if (rd !== 64'hFFFFFFFFFFFF8001) begin n_err++; $display("FAIL half_signed: got %h exp ffffffffffff8001", rd); end
    do_req(1'b0, 32'h020, 1, 1'b1, 64'd0, rd, err, lat);
    n_vec++; if (rd !== 64'h0000000000008001) begin n_err++; $display("FAIL half_unsigned: got %h exp 0000000000008001", rd); end
    do_req(1'b0, 32'h021, 0, 1'b0, 64'd0, rd, err, lat);
    n_vec++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin n_err++; $display("FAIL byte_signed: got %h exp ffffffffffffff80", rd); end
  endtask

  task automatic test_errors();
    logic [63:0] rd, erd;
    logic err, eerr;
    int lat;
    do_req(1'b0, 32'h022, 2, 1'b0, 64'd0, rd, err, lat);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL misalign_err: got %b exp 1", err); end
    n_vec++; if (rd !== 64'd0) begin n_err++; $display("FAIL misalign_rdata: got %h exp 0", rd); end
    do_req(1'b1, 32'h404, 3, 1'b0, 64'hDEADBEEFCAFEF00D, rd, err, lat);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL range_err: got %b exp 1", err); end
    n_vec++; if (lat != int'(RL)) begin n_err++; $display("FAIL range_lat: got %0d exp %0d", lat, RL); end
    model(1'b0, 32'h000, 3, 1'b0, 64'd0, eerr, erd);
    do_req(1'b0, 32'h000, 3, 1'b0, 64'd0, rd, err, lat);
    n_vec++; if (rd !== erd) begin n_err++; $display("FAIL range_nowrite: got %h exp %h", rd, erd); end
    model(1'b0, 32'h020, 3, 1'b0, 64'd0, eerr, erd);
    do_req(1'b1, 32'h023, 1, 1'b0, 64'h5555, rd, err, lat);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL misalign_store_err: got %b exp 1", err); end
    do_req(1'b0, 32'h020, 3, 1'b0, 64'd0, rd, err, lat);
    n_vec++; if (rd !== erd) begin n_err++; $display("FAIL misalign_nowrite: got %h exp %h", rd, erd); end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd, erd, wd;
    logic err, eerr;
    int lat;
    model(1'b0, 32'h100, 3, 1'b0, 64'd0, eerr, erd);
    drive(1'b0, 32'h100, 3, 1'b0, 64'd0);
    @(posedge clk); #1;
    wd = {$urandom, $urandom};
    drive(1'b1, 32'h108, 3, 1'b0, wd);
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat != int'(RL)) begin n_err++; $display("FAIL bp_lat: got %0d exp %0d", lat, RL); end
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== erd || o_req_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b rd=%h rdy=%b exp v=1 rd=%h rdy=0", c, o_rsp_valid, o_rsp_rdata, o_req_ready, erd);
      end
      @(posedge clk); #1;
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    n_vec++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release: got v=%b rdy=%b exp v=0 rdy=1", o_rsp_valid, o_req_ready);
    end
    model(1'b1, 32'h108, 3, 1'b0, wd, eerr, erd);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat != int'(RL) || o_rsp_err !== 1'b0) begin
      n_err++; $display("FAIL bp_held_store: got lat=%0d err=%b exp lat=%0d err=0", lat, o_rsp_err, RL);
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    do_req(1'b0, 32'h108, 3, 1'b0, 64'd0, rd, err, lat);
    n_vec++; if (rd !== wd) begin n_err++; $display("FAIL bp_raw: got %h exp %h", rd, wd); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd, erd, wd;
    logic err, eerr;
    int lat;
    wd = {$urandom, $urandom};
    model(1'b1, 32'h200, 3, 1'b0, wd, eerr, erd);
    drive(1'b1, 32'h200, 3, 1'b0, wd);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    i_arst = 1'b1;
    @(posedge clk); #1;
    i_arst = 1'b0;
    n_vec++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_state: got v=%b rdy=%b exp v=0 rdy=1", o_rsp_valid, o_req_ready);
    end
    i_rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_noresp[%0d]: got %b exp 0", c, o_rsp_valid); end
    end
    i_rsp_ready = 1'b0;
    do_req(1'b0, 32'h200, 3, 1'b0, 64'd0, rd, err, lat);
    n_vec++; if (rd !== wd) begin n_err++; $display("FAIL midrst_store_kept: got %h exp %h", rd, wd); end
    model(1'b0, 32'h208, 3, 1'b0, 64'd0, eerr, erd);
    i_arst = 1'b1;
    drive(1'b1, 32'h208, 3, 1'b0, ~erd);
    @(posedge clk); #1;
    i_arst = 1'b0;
    i_req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_vec++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
        n_err++; $display("FAIL rst_prio[%0d]: got v=%b rdy=%b exp v=0 rdy=1", c, o_rsp_valid, o_req_ready);
      end
      @(posedge clk); #1;
    end
    do_req(1'b0, 32'h208, 3, 1'b0, 64'd0, rd, err, lat);
    n_vec++; if (rd !== erd) begin n_err++; $display("FAIL rst_prio_nowrite: got %h exp %h", rd, erd); end
  endtask

  task automatic test_random();
    logic [63:0] rd, erd, wd;
    logic err, eerr, we, uns;
    int unsigned addr, size;
    int lat;
    for (int t = 0; t < 150; t++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = $urandom_range(0, 3);
      addr = $urandom_range(0, DEPTH * 8 + 63);
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 1);
      wd = {$urandom, $urandom};
      model(we, addr, size, uns, wd, eerr, erd);
      do_req(we, addr, size, uns, wd, rd, err, lat);
      n_vec++; if (err !== eerr || rd !== erd || lat != int'(RL)) begin
        n_err++; $display("FAIL rand[%0d] we=%b a=%h sz=%0d u=%b: got err=%b rd=%h lat=%0d exp err=%b rd=%h lat=%0d",
                          t, we, addr, size, uns, err, rd, lat, eerr, erd, RL);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_double();
    test_byte_lanes();
    test_extension();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
